cascade_counter: RTL and testbench
==================================

Name: cascade_counter

Overview:
Parametrised multi-digit cascaded counter. Generalises the two-nibble ripple-style counter to NUM_DIGITS digits of DIGIT_W bits with a programmable per-digit modulus (binary or BCD). Adds enable, up/down, synchronous load, clear, wrap/saturate mode, and a terminal-count pulse. Used as a timebase or event counter feeding display and timer logic.

Parameters:
NUM_DIGITS, 2, number of cascaded digits (>=1); digit 0 is least significant
DIGIT_W, 4, bits per digit (>=1)
MODULUS, 16, counts per digit (2..2**DIGIT_W); digit range 0..MODULUS-1; 10 gives BCD
SATURATE, 0, 0 = wrap at the terminal value; 1 = hold at the terminal value

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-low reset
en  in  1  count enable; one step per cycle while high
up_dn  in  1  1 = count up, 0 = count down
clear  in  1  synchronous clear of all digits to 0
load  in  1  synchronous parallel load
load_val  in  NUM_DIGITS*DIGIT_W  load value; digit i at bits [i*DIGIT_W +: DIGIT_W]
count  out  NUM_DIGITS*DIGIT_W  live counter value, registered; same packing as load_val
out  out  NUM_DIGITS*DIGIT_W  count delayed by one cycle (snapshot register)
tc  out  1  terminal-count pulse, one cycle
busy_max  out  1  combinational: all digits == MODULUS-1
busy_zero  out  1  combinational: all digits == 0

Behaviour:
- All state updates on the rising edge of clk. rst sampled only at the edge; rst==0 forces count=0, out=0, tc=0.
- Priority per edge: rst > clear > load > en. When none is active, count holds and tc=0.
- clear: count<=0, tc<=0. Ignores en/load.
- load: each digit is loaded from load_val. A digit value >= MODULUS is clamped to MODULUS-1. tc<=0.
- Up-count with en=1 and up_dn=1:
  - Digit 0 steps every cycle.
  - Digit i (i>0) steps only when every lower digit equals MODULUS-1.
  - A stepping digit at MODULUS-1 becomes 0. Otherwise it increments by 1.
- Down-count with en=1 and up_dn=0:
  - Digit i (i>0) steps only when every lower digit equals 0.
  - A stepping digit at 0 becomes MODULUS-1. Otherwise it decrements by 1.
- Terminal event: up with all digits at MODULUS-1, or down with all digits at 0.
  - SATURATE=0: the counter wraps (all 0 for up, all MODULUS-1 for down), and tc<=1 on that same edge, so tc is high for the cycle in which count shows the wrapped value.
  - SATURATE=1: count holds, and tc<=1 on every edge where en=1 and the terminal condition holds. tc therefore stays high while saturated and enabled.
- out<=count on every edge not in reset. This gives a fixed 1-cycle lag behind count. clear and load do not bypass it.
- Direction change (up_dn toggled) takes effect on the next enabled edge, with no dead cycle.
- en=0: count frozen and tc=0. out still tracks count, so it converges after 1 cycle.
- Reset mid-count: next edge forces all outputs to 0 regardless of en/load/clear. Counting resumes on the first edge with rst==1.
- Widths: arithmetic is per digit in DIGIT_W bits. No carry ever propagates except via the cascade rule above. Digit values are never >= MODULUS after reset.
- busy_max/busy_zero are decoded from count only, with no dependence on en.

Test Plan:
- NUM_DIGITS=2, DIGIT_W=4, MODULUS=10 (BCD), SATURATE=0: rst low 2 cycles, then en=1, up_dn=1 for 100 cycles. Required: count steps 0x00..0x99, then 0x00; tc high exactly 1 cycle, when count==0x00 after 0x99; out equals the previous cycle's count throughout.
- Same config, load=1 with load_val=0x10, then en=1, up_dn=0. Required: 0x10 -> 0x09 -> 0x08; at 0x00 the next step gives 0x99 with tc=1.
- MODULUS=16, SATURATE=1, up: load 0xFE, en=1. Required: 0xFE -> 0xFF, then holds 0xFF; tc=1 on every enabled cycle at 0xFF; busy_max=1.
- Priority: at count 0x37 assert clear, load (0x55) and en together. Required: count=0x00. Next cycle load+en gives 0x55, not 0x56.
- Clamp: BCD config, load_val=0xAF. Required: count=0x99.
- Mid-run reset: while counting at 0x42, drive rst=0 for 1 edge with en=1. Required: count=0, out=0, tc=0 after that edge; next edge with rst=1 gives count=0x01.

Source files
------------

// File: rtl/cascade_counter.sv
// cascade_counter
//   Multi-digit cascaded counter. It has NUM_DIGITS digits of DIGIT_W bits,
//   and every digit counts modulo MODULUS (10 gives BCD, 2**DIGIT_W gives plain
//   binary). Digit 0 is the least significant digit. A higher digit steps only
//   when every lower digit is at its rollover value for the current direction.
//   The counter either wraps at the terminal value or holds there, as chosen by
//   SATURATE.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset (clears count, out and tc)
//   en         count enable; one step per enabled edge
//   up_dn      1 = count up, 0 = count down
//   clear      synchronous clear of all digits (outranks load and en)
//   load       synchronous parallel load (outranks en); digits are clamped to MODULUS-1
//   load_val   load value; digit i at [i*DIGIT_W +: DIGIT_W]
//   count      registered live counter value, same packing as load_val
//   out        count delayed by one cycle
//   tc         one-cycle terminal-count pulse (held while saturated and enabled)
//   busy_max   combinational: every digit equals MODULUS-1
//   busy_zero  combinational: every digit equals 0
module cascade_counter #(
  parameter int NUM_DIGITS = 2,
  parameter int DIGIT_W    = 4,
  parameter int MODULUS    = 16,
  parameter int SATURATE   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          up_dn,
  input  logic                          clear,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
  output logic [NUM_DIGITS*DIGIT_W-1:0] count,
  output logic [NUM_DIGITS*DIGIT_W-1:0] out,
  output logic                          tc,
  output logic                          busy_max,
  output logic                          busy_zero
);

  localparam int                 W          = NUM_DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0] DMAX       = DIGIT_W'(MODULUS - 1);
  // A clamp is only possible when the digit field can hold values >= MODULUS.
  localparam bit                 NEED_CLAMP = (MODULUS < (2 ** DIGIT_W));

  // Clamp an out-of-range load digit to the largest legal digit value.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    if (NEED_CLAMP && (d > DMAX))
      return DMAX;
    return d;
  endfunction

  function automatic logic [DIGIT_W-1:0] inc_digit(input logic [DIGIT_W-1:0] d);
    return (d == DMAX) ? '0 : d + DIGIT_W'(1);
  endfunction

  function automatic logic [DIGIT_W-1:0] dec_digit(input logic [DIGIT_W-1:0] d);
    return (d == '0) ? DMAX : d - DIGIT_W'(1);
  endfunction

  logic [W-1:0] count_p0;
  logic         tc_p0;
  logic [W-1:0] out_p1;

  logic [W-1:0] count_nxt;
  logic [W-1:0] load_nxt;
  logic         tc_nxt;
  logic         all_max;
  logic         all_zero;
  logic         terminal;

  // Next-state decode. all_max/all_zero are built up from digit 0 upwards, so
  // inside the loop they give the state of the digits below digit i. This is
  // the cascade enable for digit i.
  always_comb begin
    count_nxt = count_p0;
    load_nxt  = '0;
    tc_nxt    = 1'b0;
    all_max   = 1'b1;
    all_zero  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_nxt[i*DIGIT_W +: DIGIT_W] = clamp_digit(load_val[i*DIGIT_W +: DIGIT_W]);
      if (en) begin
        if (up_dn && all_max)
          count_nxt[i*DIGIT_W +: DIGIT_W] = inc_digit(count_p0[i*DIGIT_W +: DIGIT_W]);
        else if (!up_dn && all_zero)
          count_nxt[i*DIGIT_W +: DIGIT_W] = dec_digit(count_p0[i*DIGIT_W +: DIGIT_W]);
      end
      all_max  = all_max  & (count_p0[i*DIGIT_W +: DIGIT_W] == DMAX);
      all_zero = all_zero & (count_p0[i*DIGIT_W +: DIGIT_W] == '0);
    end
    terminal = up_dn ? all_max : all_zero;
    // In wrap mode the cascade already produces the wrapped value.
    // In saturate mode the counter holds instead.
    if (en && terminal) begin
      tc_nxt = 1'b1;
      if (SATURATE != 0)
        count_nxt = count_p0;
    end
  end

  // Stage p0: live count and terminal-count pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_p0 <= '0;
      tc_p0    <= 1'b0;
    end else if (clear) begin
      count_p0 <= '0;
      tc_p0    <= 1'b0;
    end else if (load) begin
      count_p0 <= load_nxt;
      tc_p0    <= 1'b0;
    end else begin
      count_p0 <= count_nxt;
      tc_p0    <= tc_nxt;
    end
  end

  // Stage p1: one-cycle snapshot of the count
  always_ff @(posedge clk) begin
    if (!rst)
      out_p1 <= '0;
    else
      out_p1 <= count_p0;
  end

  assign count     = count_p0;
  assign tc        = tc_p0;
  assign out       = out_p1;
  assign busy_max  = all_max;
  assign busy_zero = all_zero;

endmodule

// File: tb/tb_cascade_counter.sv
// Bench for cascade_counter. Two instances share one set of inputs:
//   dut_bcd : 2 digits x 4 bits, MODULUS 10, wrap
//   dut_sat : 2 digits x 4 bits, MODULUS 16, saturate
// The reference model holds each counter as one integer in 0..MODULUS**2-1.
// It steps this integer with plain +1/-1 arithmetic and converts it to packed
// digits only when it compares against the DUT.
module tb_cascade_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, clear, load;
  logic [7:0] load_val;

  logic [7:0] b_count, b_out, s_count, s_out;
  logic       b_tc, b_bmax, b_bzero, s_tc, s_bmax, s_bzero;

  always #5 clk = ~clk;

  cascade_counter #(.NUM_DIGITS(2), .DIGIT_W(4), .MODULUS(10), .SATURATE(0)) dut_bcd (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .count(b_count), .out(b_out), .tc(b_tc),
    .busy_max(b_bmax), .busy_zero(b_bzero)
  );

  cascade_counter #(.NUM_DIGITS(2), .DIGIT_W(4), .MODULUS(16), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .count(s_count), .out(s_out), .tc(s_tc),
    .busy_max(s_bmax), .busy_zero(s_bzero)
  );

  int   passed = 0;
  int   total  = 0;
  int   tcs;
  int   m_mod[2] = '{10, 16};
  int   m_sat[2] = '{0, 1};
  int   m_cnt[2] = '{0, 0};
  int   m_out[2] = '{0, 0};
  logic m_tc[2]  = '{1'b0, 1'b0};

  // Interpret load_val as two digits, clamping each digit to mod-1.
  function automatic int load_value(input logic [7:0] v, input int mod);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > mod - 1) hi = mod - 1;
    if (lo > mod - 1) lo = mod - 1;
    return hi * mod + lo;
  endfunction

  function automatic logic [7:0] enc(input int v, input int mod);
    logic [3:0] hi, lo;
    hi = 4'(v / mod);
    lo = 4'(v % mod);
    return {hi, lo};
  endfunction

  task automatic model_edge();
    int top;
    for (int k = 0; k < 2; k++) begin
      top = m_mod[k] * m_mod[k] - 1;
      if (!rst) begin
        m_cnt[k] = 0; m_out[k] = 0; m_tc[k] = 1'b0;
      end else begin
        m_out[k] = m_cnt[k];
        m_tc[k]  = 1'b0;
        if (clear) m_cnt[k] = 0;
        else if (load) m_cnt[k] = load_value(load_val, m_mod[k]);
        else if (en) begin
          if (up_dn) begin
            if (m_cnt[k] == top) begin
              m_tc[k] = 1'b1;
              if (m_sat[k] == 0) m_cnt[k] = 0;
            end else m_cnt[k] = m_cnt[k] + 1;
          end else begin
            if (m_cnt[k] == 0) begin
              m_tc[k] = 1'b1;
              if (m_sat[k] == 0) m_cnt[k] = top;
            end else m_cnt[k] = m_cnt[k] - 1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("bcd_count", 32'(b_count), 32'(enc(m_cnt[0], 10)));
    chk("bcd_out",   32'(b_out),   32'(enc(m_out[0], 10)));
    chk("bcd_tc",    32'(b_tc),    32'(m_tc[0]));
    chk("bcd_bmax",  32'(b_bmax),  32'(m_cnt[0] == 99));
    chk("bcd_bzero", 32'(b_bzero), 32'(m_cnt[0] == 0));
    chk("sat_count", 32'(s_count), 32'(enc(m_cnt[1], 16)));
    chk("sat_out",   32'(s_out),   32'(enc(m_out[1], 16)));
    chk("sat_tc",    32'(s_tc),    32'(m_tc[1]));
    chk("sat_bmax",  32'(s_bmax),  32'(m_cnt[1] == 255));
    chk("sat_bzero", 32'(s_bzero), 32'(m_cnt[1] == 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0; load_val = 8'h00;

    // Reset held for two edges
    step();
    step();
    chk("reset_count", 32'(b_count), 32'h00);
    chk("reset_out",   32'(b_out),   32'h00);
    chk("reset_tc",    32'(b_tc),    32'h0);

    // BCD up-count through a full wrap
    rst = 1'b1; en = 1'b1; up_dn = 1'b1;
    tcs = 0;
    for (int i = 0; i < 99; i++) begin
      step();
      if (b_tc) tcs = tcs + 1;
    end
    chk("bcd_at_99", 32'(b_count), 32'h99);
    step();
    if (b_tc) tcs = tcs + 1;
    chk("bcd_wrap_0",  32'(b_count), 32'h00);
    chk("bcd_wrap_tc", 32'(b_tc),    32'h1);
    chk("bcd_tc_once", 32'(tcs),     32'd1);

    // Load 0x10 then count down through the underflow wrap
    load = 1'b1; load_val = 8'h10;
    step();
    chk("bcd_load10", 32'(b_count), 32'h10);
    load = 1'b0; up_dn = 1'b0;
    step();
    chk("bcd_dn_09", 32'(b_count), 32'h09);
    step();
    chk("bcd_dn_08", 32'(b_count), 32'h08);
    for (int i = 0; i < 8; i++) step();
    chk("bcd_dn_00", 32'(b_count), 32'h00);
    step();
    chk("bcd_dn_wrap",    32'(b_count), 32'h99);
    chk("bcd_dn_wrap_tc", 32'(b_tc),    32'h1);

    // Saturating hex counter at the top
    load = 1'b1; load_val = 8'hFE; up_dn = 1'b1;
    step();
    chk("sat_load_fe", 32'(s_count), 32'hFE);
    load = 1'b0;
    step();
    chk("sat_ff",    32'(s_count), 32'hFF);
    chk("sat_ff_tc", 32'(s_tc),    32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_hold",    32'(s_count), 32'hFF);
      chk("sat_hold_tc", 32'(s_tc),    32'h1);
      chk("sat_bmax1",   32'(s_bmax),  32'h1);
    end

    // Priority clear > load > en
    load = 1'b1; load_val = 8'h37; en = 1'b0;
    step();
    chk("prio_37", 32'(b_count), 32'h37);
    clear = 1'b1; load_val = 8'h55; en = 1'b1;
    step();
    chk("prio_clear", 32'(b_count), 32'h00);
    clear = 1'b0;
    step();
    chk("prio_load", 32'(b_count), 32'h55);

    // Clamp of out-of-range digits
    load_val = 8'hAF;
    step();
    chk("clamp_bcd", 32'(b_count), 32'h99);
    chk("clamp_hex", 32'(s_count), 32'hAF);

    // Reset in the middle of a count
    load_val = 8'h41;
    step();
    load = 1'b0; up_dn = 1'b1;
    step();
    chk("mid_42", 32'(b_count), 32'h42);
    rst = 1'b0;
    step();
    chk("mid_rst_count", 32'(b_count), 32'h00);
    chk("mid_rst_out",   32'(b_out),   32'h00);
    chk("mid_rst_tc",    32'(b_tc),    32'h0);
    rst = 1'b1;
    step();
    chk("mid_resume", 32'(b_count), 32'h01);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 39) != 0);
      clear    = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = 1'($urandom_range(0, 1));
      load_val = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
